// File: rtl/pipe_stage_skid_pkg.sv
// pipe_stage_skid_pkg
//   Shared constants for the elastic pipeline stage: the bubble instruction
//   and the skid-buffer occupancy state encoding.
package pipe_stage_skid_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// pipe_entry
//   Load-enabled {instr, pc, data} register with synchronous clear.
//   Clear has priority over load.
// Ports:
//   clk, clear       clock and synchronous clear (active high)
//   load             capture d_* on the next edge
//   d_instr/pc/data  next entry contents
//   q_instr/pc/data  held entry contents
module pipe_entry #(
    parameter int DATA_W  = 64,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               load,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [PC_W-1:0]    d_pc,
    input  logic [DATA_W-1:0]  d_data,
    output logic [INSTR_W-1:0] q_instr,
    output logic [PC_W-1:0]    q_pc,
    output logic [DATA_W-1:0]  q_data
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q_instr <= '0;
            q_pc    <= '0;
            q_data  <= '0;
        end else if (load) begin
            q_instr <= d_instr;
            q_pc    <= d_pc;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Elastic pipeline-stage register with a 2-entry skid buffer. in_ready is
//   decoded from the registered occupancy state only, so there is no
//   combinational path from out_ready to in_ready. flush squashes both
//   entries (bubble insertion); reset has priority over flush.
//   Optional macro PIPE_PERF_CNT_EN adds saturating stall/bubble counters.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   flush                           drop all held entries and any push
//   in_valid/in_ready               upstream handshake
//   in_instr/in_pc/in_data          incoming entry
//   out_valid/out_ready             downstream handshake
//   out_instr/out_pc/out_data       main entry (out_instr = NOP when invalid)
//   stall_cnt/bubble_cnt            perf counters (PIPE_PERF_CNT_EN only)
//
// state    | meaning
// ---------+--------------------------------
// ST_EMPTY | no entry held
// ST_ONE   | main entry valid
// ST_TWO   | main and skid entries valid
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [DATA_W-1:0]  out_data
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
`endif
);

    state_t state;

    logic push;
    logic pop;
    logic clear;
    logic main_load;
    logic skid_load;

    logic [INSTR_W-1:0] main_instr, skid_instr, main_d_instr;
    logic [PC_W-1:0]    main_pc,    skid_pc,    main_d_pc;
    logic [DATA_W-1:0]  main_data,  skid_data,  main_d_data;

    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign clear     = reset | flush;

    // Main refills from the skid when draining TWO, otherwise from the input.
    assign main_load = ((state == ST_EMPTY) & push)
                     | ((state == ST_ONE) & push & pop)
                     | ((state == ST_TWO) & pop);
    assign skid_load = (state == ST_ONE) & push & ~pop;

    always_comb begin
        main_d_instr = in_instr;
        main_d_pc    = in_pc;
        main_d_data  = in_data;
        if (state == ST_TWO) begin
            main_d_instr = skid_instr;
            main_d_pc    = skid_pc;
            main_d_data  = skid_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (push) state <= ST_ONE;
                ST_ONE: begin
                    if (push && !pop)      state <= ST_TWO;
                    else if (!push && pop) state <= ST_EMPTY;
                end
                ST_TWO:   if (pop) state <= ST_ONE;
                default:  state <= ST_EMPTY;
            endcase
        end
    end

    pipe_entry #(.DATA_W(DATA_W), .PC_W(PC_W), .INSTR_W(INSTR_W)) u_main (
        .clk     (clk),
        .clear   (clear),
        .load    (main_load),
        .d_instr (main_d_instr),
        .d_pc    (main_d_pc),
        .d_data  (main_d_data),
        .q_instr (main_instr),
        .q_pc    (main_pc),
        .q_data  (main_data)
    );

    pipe_entry #(.DATA_W(DATA_W), .PC_W(PC_W), .INSTR_W(INSTR_W)) u_skid (
        .clk     (clk),
        .clear   (clear),
        .load    (skid_load),
        .d_instr (in_instr),
        .d_pc    (in_pc),
        .d_data  (in_data),
        .q_instr (skid_instr),
        .q_pc    (skid_pc),
        .q_data  (skid_data)
    );

    // Downstream decode must see a bubble whenever nothing is valid.
    assign out_instr = out_valid ? main_instr : INSTR_W'(NOP_INSTR);
    assign out_pc    = main_pc;
    assign out_data  = main_data;

`ifdef PIPE_PERF_CNT_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (!out_valid && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised elastic pipeline-stage register for the multi-stage CPU datapath; generalises the fixed-width stage latches (instr/pc/payload).
- Uses a valid/ready handshake with a 2-entry skid buffer, so backpressure does not need a combinational ready path through the stage.
- Supports synchronous flush (bubble insertion) for branch/exception squash.

Parameters:
- DATA_W, 64, width of the generic payload (e.g. ALU result + DM read data).
- PC_W, 32, width of the pc field.
- INSTR_W, 32, width of the instruction field.
- CNT_W, 32, width of the performance counters; used only with PIPE_PERF_CNT_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries this cycle.
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  stage can accept an entry; registered.
- in_instr  in  INSTR_W  instruction.
- in_pc  in  PC_W  pc.
- in_data  in  DATA_W  payload.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  INSTR_W  instruction; NOP when out_valid=0.
- out_pc  out  PC_W  pc.
- out_data  out  DATA_W  payload.
- stall_cnt  out  CNT_W  only with PIPE_PERF_CNT_EN.
- bubble_cnt  out  CNT_W  only with PIPE_PERF_CNT_EN.

Behaviour:
- Reset (clk edge with reset=1): state EMPTY; out_valid=0; out_instr/out_pc/out_data=0; in_ready=1; counters=0. Reset beats flush and all handshakes.
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Both are evaluated at the clk edge.
- States (2-bit): EMPTY (no entry), ONE (main entry valid), TWO (main + skid valid).
- EMPTY: push -> ONE, data loads into main. Otherwise stay.
- ONE: push & pop -> ONE, main reloads from input. Push & !pop -> TWO, data goes to skid. !push & pop -> EMPTY. Otherwise stay.
- TWO: pop -> ONE, main loads from skid. in_ready=0, so no push is possible.
- in_ready = (state != TWO), driven from a registered state only. There is no combinational path from out_ready to in_ready.
- out_valid = (state != EMPTY). Outputs always show the main entry.
- Latency: input to output is 1 cycle. Sustained throughput is 1 entry/cycle when out_ready is held high.
- Hold: while out_valid & !out_ready, out_* must stay bit-stable until a pop.
- Ordering: strict FIFO; entries are never reordered or duplicated.
- Flush=1 (no reset): next state EMPTY. Any push that cycle is dropped. out_instr=NOP (0), out_pc=0, out_data=0. A pop that cycle is still honoured downstream for the current entry.
- When out_valid=0, out_instr is forced to NOP (0) so downstream decode sees a bubble.
- Reset mid-transfer discards both entries with no partial state kept.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with out_valid & !out_ready.
  - bubble_cnt increments on every cycle with !out_valid.
  - Both counters saturate at all-ones, clear on reset, and are not cleared by flush.
- Undefined: the stall_cnt/bubble_cnt ports and their logic are absent. Handshake behaviour is identical.

Decomposition:
- Shared constants file:
  - NOP_INSTR (32'h0000_0000).
  - State encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
- One natural sub-module: pipe_entry, a load-enabled {instr,pc,data} register with synchronous clear. Instantiate it twice (main, skid).

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> out_valid=0, out_instr=0, in_ready=1. With the macro, bubble_cnt counts 1 per idle cycle after reset release.
- Streaming: out_ready=1, push pc=0x3000,0x3004,0x3008 on consecutive cycles -> each appears 1 cycle later, in order, with in_ready constantly 1.
- Backpressure: out_ready=0, push pc=0x3000 then 0x3004 -> state TWO, in_ready=0, out_pc held at 0x3000. Raise out_ready -> 0x3000 then 0x3004 pop on successive cycles, and in_ready returns to 1 one cycle after the first pop.
- Flush while in state TWO with in_valid=1 (pc=0x3010) -> next cycle out_valid=0, out_instr=0, in_ready=1; 0x3010 is never output.
- Simultaneous push & pop in ONE: main=0x3000, push 0x3004, out_ready=1 -> next cycle out_pc=0x3004, state ONE.
- Stall counting (macro defined): hold out_ready=0 for 5 cycles with out_valid=1 -> stall_cnt=5. Preload to all-ones-1 with 3 stall cycles -> stall_cnt saturates at all-ones.
